// File: rtl/limbus_sys_acortex_st_chan_tracker.sv
// Per-channel Avalon-ST framing tracker: read-modify-writes a 2-bit state word per beat in an external state RAM.
// Optional `ACORTEX_ST_ERR_STICKY_EN: keep the err bit so every later beat of a violated packet is flagged.
module limbus_sys_acortex_st_chan_tracker #(
  parameter int CHANNEL_WIDTH = 1,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic                     out_error,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [CHANNEL_WIDTH-1:0] st_wr_address,
  output logic [1:0]               st_wr_writedata,
  output logic                     st_wr_write,
  input  logic                     st_wr_waitrequest,
  output logic [CHANNEL_WIDTH-1:0] st_rd_address,
  input  logic [1:0]               st_rd_readdata
);

`ifdef ACORTEX_ST_ERR_STICKY_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OPEN = 2'b01;

  // Returns {beat_error, next_state} for one beat given the stored state word {err, inpkt}.
  function automatic logic [2:0] frame_update(input logic sop, input logic eop, input logic [1:0] prev);
    logic       err;
    logic [1:0] open_state;
    if (sop) begin
      err        = prev[0];
      open_state = ST_OPEN;
    end else if (!prev[0]) begin
      err        = 1'b1;
      open_state = {STICKY_EN, 1'b1};
    end else begin
      err        = STICKY_EN & prev[1];
      open_state = {STICKY_EN & prev[1], 1'b1};
    end
    return {err, (eop ? ST_IDLE : open_state)};
  endfunction

  logic                     s1_valid_r;
  logic                     s1_sop_r;
  logic                     s1_eop_r;
  logic [CHANNEL_WIDTH-1:0] s1_channel_r;
  logic [DATA_WIDTH-1:0]    s1_data_r;
  logic                     out_valid_r;
  logic                     out_sop_r;
  logic                     out_eop_r;
  logic                     out_error_r;
  logic [CHANNEL_WIDTH-1:0] out_channel_r;
  logic [DATA_WIDTH-1:0]    out_data_r;
  logic                     ready_en_r;
  logic                     adv_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic [2:0]               upd_s;

  // Handshake, RAM read address and state write-back for the beat leaving S1.
  always_comb begin
    adv_s           = ~out_valid_r | out_ready;
    in_ready_s      = adv_s & ~st_wr_waitrequest & ready_en_r;
    accept_s        = in_valid & in_ready_s;
    upd_s           = frame_update(s1_sop_r, s1_eop_r, st_rd_readdata);
    st_wr_write     = s1_valid_r & adv_s;
    st_wr_address   = s1_channel_r;
    st_wr_writedata = upd_s[1:0];
    if (adv_s) begin
      st_rd_address = in_channel;
    end else begin
      st_rd_address = s1_channel_r;
    end
  end

  // Keeps in_ready low through reset, independent of the RAM's waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // S1 and output register advance together; both hold during a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r    <= 1'b0;
      s1_sop_r      <= 1'b0;
      s1_eop_r      <= 1'b0;
      s1_channel_r  <= {CHANNEL_WIDTH{1'b0}};
      s1_data_r     <= {DATA_WIDTH{1'b0}};
      out_valid_r   <= 1'b0;
      out_sop_r     <= 1'b0;
      out_eop_r     <= 1'b0;
      out_error_r   <= 1'b0;
      out_channel_r <= {CHANNEL_WIDTH{1'b0}};
      out_data_r    <= {DATA_WIDTH{1'b0}};
    end else if (adv_s) begin
      s1_valid_r    <= accept_s;
      s1_sop_r      <= in_startofpacket;
      s1_eop_r      <= in_endofpacket;
      s1_channel_r  <= in_channel;
      s1_data_r     <= in_data;
      out_valid_r   <= s1_valid_r;
      out_sop_r     <= s1_sop_r;
      out_eop_r     <= s1_eop_r;
      out_error_r   <= s1_valid_r & upd_s[2];
      out_channel_r <= s1_channel_r;
      out_data_r    <= s1_data_r;
    end
  end

  assign in_ready          = in_ready_s;
  assign out_valid         = out_valid_r;
  assign out_startofpacket = out_sop_r;
  assign out_endofpacket   = out_eop_r;
  assign out_error         = out_error_r;
  assign out_channel       = out_channel_r;
  assign out_data          = out_data_r;

endmodule

// File: doc/limbus_sys_acortex_st_chan_tracker.md
# limbus_sys_acortex_st_chan_tracker

- Per-channel Avalon-ST packet-framing tracker that sits in front of the acortex channel adaptor.
- Drives the read and write ports of the adaptor's lookahead state RAM as their initiator: read-modify-write of a 2-bit state word per channel for every accepted beat.
- Forwards each beat with an `out_error` flag marking framing violations (orphan beats, truncated packets).

## Interface
Parameters:
- `CHANNEL_WIDTH`, 1: channel field width. The state RAM depth is 2**CHANNEL_WIDTH.
- `DATA_WIDTH`, 16: beat payload width.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous assert, active-low.
- `in_valid`, `in_startofpacket`, `in_endofpacket` in 1 each: sink stream qualifiers.
- `in_channel` in CHANNEL_WIDTH; `in_data` in DATA_WIDTH: sink beat.
- `in_ready` out 1: sink backpressure.
- `out_valid`, `out_startofpacket`, `out_endofpacket`, `out_error` out 1 each: source stream qualifiers.
- `out_channel` out CHANNEL_WIDTH; `out_data` out DATA_WIDTH: source beat.
- `out_ready` in 1: source backpressure.
- `st_wr_address` out CHANNEL_WIDTH; `st_wr_writedata` out 2; `st_wr_write` out 1: state RAM write port.
- `st_wr_waitrequest` in 1: high while the RAM clears itself after reset.
- `st_rd_address` out CHANNEL_WIDTH; `st_rd_readdata` in 2: state RAM read port. Data is valid the cycle after the address edge. The RAM forwards writes issued in the same or the following cycle.

## Operation
State word: bit0 `inpkt`, bit1 `err`. Reset value 00 is provided by the RAM clear.

Two-stage pipeline:
- **S1 register:** captures the accepted beat. `st_rd_address` = `in_channel` when `adv`, else the S1 channel, so the read is held during a stall.
- **Output register:** S1 moves to the output register on `adv`. In the same cycle `st_wr_write`=1, `st_wr_address`=S1 channel, `st_wr_writedata`=new state.
- `adv` = !`out_valid` | `out_ready`.
- `in_ready` = `adv` & !`st_wr_waitrequest`.

Per-beat rules, with p = `st_rd_readdata`:
- SOP, any EOP: `out_error` = p.inpkt (previous packet truncated). New state = EOP ? 00 : 01.
- No SOP, p.inpkt=0 (orphan): `out_error`=1. New state = EOP ? 00 : 11.
- No SOP, p.inpkt=1: `out_error` = p.err. New state = EOP ? 00 : p.
- Data, channel, SOP and EOP pass through unmodified.

Boundary conditions:
- Back-to-back beats on the same channel rely on RAM write-forwarding. No internal bypass is permitted.
- Stall (`adv`=0): S1 and the output register hold, `st_wr_write`=0. Exactly one write per beat.
- `st_wr_waitrequest` high: `in_ready`=0, `st_wr_write`=0. The S1 and output registers are empty by construction.
- Reset mid-packet: all pipeline contents are discarded. The RAM re-clears, so every channel restarts idle.

## Timing
- Reset values: `out_valid`=0, `out_error`=0, `out_startofpacket`=0, `out_endofpacket`=0, `out_channel`=0, `out_data`=0, `st_wr_write`=0, `in_ready`=0.
- `in_ready` may rise only once `st_wr_waitrequest` has fallen.
- Latency: a beat accepted at edge E appears on `out_*` after edge E+1, assuming no stall. Throughput is one beat per cycle.
- `st_rd_address`, `st_wr_*` and `in_ready` are combinational from registers and `out_ready`/`st_wr_waitrequest`. They have no combinational path from `in_*`, except `st_rd_address` from `in_channel`.

## Configuration
- `ACORTEX_ST_ERR_STICKY_EN` defined: behaviour as above. `err` persists, and every later beat of a violated packet carries `out_error`=1 until EOP.
- Undefined: bit1 is always written 0. Only the offending beat (orphan, or SOP onto an open packet) is flagged. Mid-packet beats report `out_error`=0.

## Test plan
- **Reset/clear:** hold `reset_n` low 2 cycles, release.
  - `in_ready`=0 until `st_wr_waitrequest`=0.
  - All outputs are at their reset values.
- **Clean packet:** ch0 SOP, 0x1111, 0x2222, EOP, back-to-back with `out_ready`=1.
  - Beats appear 2 edges later, in order, with `out_error`=0.
  - Final write to ch0 is 00.
- **Truncation:** ch1 SOP, then ch1 SOP again.
  - Second beat `out_error`=1; ch1 state is 01.
  - With the macro undefined, the following mid beat has `out_error`=0.
- **Orphan with sticky error:** ch0 mid beat with no open packet, then 2 further mid beats.
  - With the macro defined, all 3 beats have `out_error`=1.
  - An EOP beat writes 00.
- **Interleave and backpressure:** alternate ch0/ch1 packets; drop `out_ready` for 3 cycles mid-stream.
  - Output holds stable and `in_ready`=0 during the stall.
  - Exactly one `st_wr_write` per beat, and no framing errors reported.
- **Reset mid-packet:** assert `reset_n` after an SOP on ch1, then send a ch1 mid beat once `st_wr_waitrequest` clears.
  - The mid beat is flagged `out_error`=1 (orphan).
